// File: rtl/edm_buf_pkg.sv
// Shared types and defaults for the edge buffer write path.
package edm_buf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_WIDTH     = 64;
  localparam int unsigned DEF_MAX_BURST = 8;

  // Width of an index into a vector of n entries (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority selector: first set request at or after rr_ptr, wrapping.
module rr_pick
  import edm_buf_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [PW-1:0]      win_idx,
  output logic               any
);

  localparam int unsigned SW = PW + 1;

  // Scan requests starting at rr_ptr, modulo NUM_REQ; the first hit wins.
  always_comb begin
    logic [SW-1:0] pos;
    win_onehot = '0;
    win_idx    = '0;
    any        = 1'b0;
    pos        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, rr_ptr} + SW'(i);
      if (pos >= SW'(NUM_REQ)) begin
        pos = pos - SW'(NUM_REQ);
      end
      if (!any && req[pos[PW-1:0]]) begin
        any                    = 1'b1;
        win_idx                = pos[PW-1:0];
        win_onehot[pos[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
  import edm_buf_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wr,
  output logic [WIDTH-1:0]         fifo_w_data,
  input  logic                     fifo_full,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [7:0]               beat_cnt
);

  localparam int unsigned PW        = idx_width(NUM_REQ);
  localparam logic [7:0]  LAST_BEAT = 8'(MAX_BURST - 1);
  localparam logic [PW-1:0] TOP_IDX = PW'(NUM_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           beat_q, beat_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;

  logic                 transfer;
  logic                 burst_end;
  logic [PW-1:0]        owner_inc;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_pick (
    .req        (req_valid),
    .rr_ptr     (rr_ptr_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any        (pick_any)
  );

  // grant_q is the one-hot of the registered owner in BURST and zero in IDLE,
  // so ready only ever depends on registered state and fifo_full.
  assign busy      = (state_q == BURST);
  assign req_ready = (busy && !fifo_full) ? grant_q : '0;
  assign transfer  = |(req_valid & req_ready);
  assign fifo_wr   = transfer;
  assign grant     = grant_q;
  assign beat_cnt  = beat_q;

  assign owner_inc = (owner_q == TOP_IDX) ? '0 : owner_q + 1'b1;
  assign burst_end = transfer && (req_last[owner_q] || (beat_q == LAST_BEAT));

  // Data mux: owner's slice throughout the burst, zero while idle.
  always_comb begin
    fifo_w_data = '0;
    if (busy) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (owner_q == PW'(i)) begin
          fifo_w_data = req_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Next-state: arbitrate in IDLE, count beats and release in BURST.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_any) begin
          state_d = BURST;
          owner_d = pick_idx;
          grant_d = pick_onehot;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (burst_end) begin
          state_d  = IDLE;
          grant_d  = '0;
          beat_d   = '0;
          rr_ptr_d = owner_inc;
        end else if (transfer) begin
          beat_d = beat_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        beat_d  = '0;
      end
    endcase
  end

  // State register; reset discards any burst in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `mem_fifo_buf` write port among `NUM_REQ` ingress requesters. Each requester streams 64-bit words with valid/ready and a `last` flag; the arbiter grants one requester at a time for a burst, muxes its data onto the FIFO write port and back-pressures on FIFO full. It sits between the per-lane PHY word sources and the shared buffer.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 64, data word width; matches FIFO `WIDTH`
- `MAX_BURST`, 8, maximum words per grant before forced release (1..255)
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  reset, asynchronous assert, active-low
- `req_valid`  in  NUM_REQ  per-requester word valid
- `req_last`  in  NUM_REQ  per-requester last word of burst
- `req_data`  in  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero
- `fifo_wr`  out  1  drives FIFO `wr`
- `fifo_w_data`  out  WIDTH  drives FIFO `w_data`
- `fifo_full`  in  1  from FIFO `full`
- `grant`  out  NUM_REQ  registered one-hot current owner, 0 when idle
- `busy`  out  1  high in BURST state
- `beat_cnt`  out  8  words accepted in current burst

## Operation
- States: IDLE, BURST (register `state`), plus `rr_ptr` (index, log2 NUM_REQ bits), `owner` index, `beat_cnt`.
- IDLE: if any `req_valid`, pick first set bit scanning `rr_ptr`, `rr_ptr+1`, ... mod NUM_REQ; register `grant`/`owner`, `beat_cnt`<=0, go BURST. No valid: stay IDLE, `grant`=0.
- BURST: `req_ready[owner] = ~fifo_full`; all other `req_ready`=0. Transfer when `req_valid[owner] & req_ready[owner]`.
- `fifo_wr` = transfer (combinational); `fifo_w_data` = `req_data` slice of `owner` (combinational mux, held at owner slice even when not writing; 0 in IDLE).
- Each transfer: `beat_cnt`+=1.
- Burst ends on transfer with `req_last[owner]`=1, or transfer with `beat_cnt == MAX_BURST-1` (forced release). On end: `state`<=IDLE, `grant`<=0, `beat_cnt`<=0, `rr_ptr`<=owner+1 mod NUM_REQ.
- Owner dropping `req_valid` mid-burst: grant held, no timeout.
- `fifo_full` high: zero writes; burst holds until full drops. Arbiter never asserts `fifo_wr` while `fifo_full`=1.

## Timing
- Reset (async, `reset_n`=0): `state`=IDLE, `grant`=0, `rr_ptr`=0, `owner`=0, `beat_cnt`=0; hence `req_ready`=0, `fifo_wr`=0, `fifo_w_data`=0, `busy`=0. Reset mid-burst discards the burst; no partial write occurs after assertion.
- Arbitration latency: `req_valid` seen in IDLE at edge N -> `grant` and `busy` high after N; first write possible in cycle N+1.
- Throughput: 1 word/cycle within burst; exactly one idle bubble cycle between consecutive bursts (IDLE re-arbitration).
- `req_ready` depends combinationally on `fifo_full` and registered `owner` only; never on `req_valid` (no loops).
- FIFO `full` is registered in the FIFO; word written in cycle that fills FIFO is accepted, next cycle `fifo_full`=1 stops writes.
- `req_last` and forced release in same beat: single release, `rr_ptr` advances once.
- NUM_REQ=1: repeatedly grants requester 0 with one bubble between bursts.

## Structure
- Shared package `edm_buf_pkg`: `arb_state_t` (IDLE, BURST), default `WIDTH`, `MAX_BURST` constants.
- One sub-module: `rr_pick` — combinational round-robin priority selector (inputs: request vector, `rr_ptr`; outputs: one-hot winner, index, any). Remainder in `fifo_wr_arbiter`.

## Test plan
- Single requester 0 sends 3 words (A0,A1,A2 last) -> `grant`=0001 one cycle after valid, FIFO receives A0,A1,A2 on 3 consecutive cycles, `busy` drops after A2.
- Requesters 0,1,2 all valid, 2-word bursts each -> write order req0,req1,req2, then req0 again; one bubble between bursts; `rr_ptr` = 1,2,3 after each.
- Requester 1 sends 20 words with `req_last` only on word 20, MAX_BURST=8, requester 2 also valid -> req1 released after 8 words, req2 granted, req1 resumes later; total 20 req1 words in order.
- FIFO filled to 64 words with no reads -> `fifo_full`=1, `req_ready`=0, `fifo_wr`=0, no data lost; after one FIFO read, next word written.
- `reset_n` low for 1 cycle mid-burst at word 3 of 5 -> all outputs 0 immediately, `rr_ptr`=0; after release requester 0 wins first arbitration.
